eh2_ifu_compress_stream: RTL and testbench
==========================================

Name: eh2_ifu_compress_stream

Overview:
Streaming fetch-side aligner and expander for RVC. Accepts fetch beats of NPARCEL 16-bit parcels and buffers them in a parcel FIFO. Splits the FIFO contents into 16-bit compressed and 32-bit full instructions, including 32-bit instructions that span beats. Emits one expanded 32-bit instruction per cycle with its halfword PC, using the existing decompressor eh2_ifu_compress_ctl. Sits between the fetch-data return path and the decode input.

Parameters:
NPARCEL, 2, 16-bit parcels per input beat (>=1).
BUF_DEPTH, 6, parcel FIFO entries (>= NPARCEL+1).
PC_W, 31, halfword PC width (address bits [31:1]).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
flush  in  1  discard all buffered parcels and the output register
in_valid  in  1  fetch beat valid
in_ready  out  1  beat accepted when in_valid & in_ready
in_data  in  16*NPARCEL  parcel i at [16i+15:16i]
in_pc  in  PC_W  halfword PC of parcel 0
in_start  in  max(1,$clog2(NPARCEL))  index of first useful parcel; lower parcels dropped
out_valid  out  1  instruction valid
out_ready  in  1  consumer accepts when out_valid & out_ready
out_instr  out  32  expanded instruction
out_pc  out  PC_W  PC of the instruction's first parcel
out_compressed  out  1  source was 16-bit
out_illegal  out  1  compressed and expansion == 0

Behaviour:
- Reset (sync, rst=1 at clk edge): FIFO empty, wr/rd pointers 0, out_valid=0, out_instr=0, out_pc=0, out_compressed=0, out_illegal=0. in_ready=0 while rst=1.
- in_ready = !rst & !flush & (free entries >= NPARCEL). Combinational from the registered count. It does not depend on in_start.
- Beat accept: parcels in_start..NPARCEL-1 are written in order. Entry k gets pc = in_pc + k, modulo 2^PC_W.
- Head decode: parcel0 = FIFO head.
  - parcel0[1:0] != 2'b11: compressed; needs 1 entry.
  - Otherwise: 32-bit instruction = {parcel1, parcel0}; needs 2 entries.
  - With only 1 entry and a 32-bit head, wait for the next beat. No output, no stall of the input.
- Output register load: when (!out_valid | out_ready) and the head instruction is complete.
  - Loads out_instr: compressed uses the eh2_ifu_compress_ctl dout; full uses the raw 32 bits.
  - Loads out_pc = head entry pc, out_compressed, and out_illegal = compressed & (dout == 0).
  - Pops 1 or 2 entries.
- Otherwise, with out_ready=1, out_valid deasserts.
- Held output: while out_valid & !out_ready, all out_* are held stable.
- Latency: beat accepted in cycle N; first instruction has out_valid=1 in cycle N+2 (FIFO write at the end of N, output load at the end of N+1). No bypass.
- Throughput: 1 instruction/cycle with out_ready held high and a non-starving input.
- Simultaneous FIFO push and pop in the same cycle is legal; count updates by pushed - popped.
- Pointers wrap modulo BUF_DEPTH. Count never exceeds BUF_DEPTH, guaranteed by in_ready.
- Flush (sync, takes priority over everything except rst):
  - Clears the FIFO (including a pending half of a 32-bit instruction) and out_valid.
  - Any beat presented in the flush cycle is not accepted (in_ready=0).
  - The cycle after flush behaves as after reset.
- rst mid-operation is identical to flush, plus clears the out_* data regs.
- No PC continuity check between beats. The PC of parcel1 of a spanning instruction is ignored.

Decomposition:
- Shared package eh2_ifu_pkg (or the existing param include): the parcel entry typedef {16-bit data, PC_W pc} and constants RVC_FULL_OP = 2'b11 and PARCEL_W = 16.
- Sub-module: existing eh2_ifu_compress_ctl (din[15:0] -> dout[31:0]), one instance on the FIFO head parcel. The FIFO stays inline.

Test Plan:
1. Reset: hold rst=1 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, all out_* = 0. One cycle after rst drops -> in_ready=1.
2. Beat {p0=0x4505, p1=0x0001}, in_pc=0x40, in_start=0, out_ready=1 -> cycle N+2: 0x00100513 pc 0x40 compressed=1. Cycle N+3: 0x00000013 pc 0x41.
3. Spanning: beat A {0x0001, 0x0093} pc 0x40, then beat B {0x0010, 0x0085} pc 0x42 -> outputs in order:
   - 0x00000013 pc 0x40 c=1
   - 0x00100093 pc 0x41 c=0
   - 0x00108093 pc 0x43 c=1
4. Backpressure: out_ready=0 for 20 cycles with continuous beats of {0x0001, 0x0001} -> in_ready drops once free < 2. out_* stable. After release, every parcel is emitted exactly once, in PC order.
5. Flush with a pending half (beat {0x0001, 0x0093} consumed to a lone 0x0093), flush=1, then beat {0x4505, 0x0001} pc 0x80 -> next output is 0x00100513 pc 0x80. 0x0093 is never emitted.
6. Beat {0x0000, 0x4505} pc 0x20, in_start=1 -> single output 0x00100513 pc 0x21, out_illegal=0. Separately, beat {0x0000, ...} with in_start=0 -> out_instr=0, out_compressed=1, out_illegal=1.

Source files
------------

// File: rtl/eh2_ifu_pkg.sv
// Shared IFU types and constants for the compressed-instruction stream path.
package eh2_ifu_pkg;

  localparam int PARCEL_W = 16;
  localparam logic [1:0] RVC_FULL_OP = 2'b11;

  typedef logic [PARCEL_W-1:0] parcel_t;

  // RV32 base opcodes produced by the RVC expander
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/eh2_ifu_compress_ctl.sv
// RV32C to RV32I expander; reserved/unsupported encodings expand to 0.
module eh2_ifu_compress_ctl
  import eh2_ifu_pkg::*;
(
  input  logic [15:0] din,
  output logic [31:0] dout
);

  logic [4:0]  rd, rs2, rdp, rs1p;
  logic [11:0] imm6s;

  assign rd    = din[11:7];
  assign rs2   = din[6:2];
  assign rdp   = {2'b01, din[4:2]};
  assign rs1p  = {2'b01, din[9:7]};
  assign imm6s = {{6{din[12]}}, din[12], din[6:2]};

  // Decode by {funct3, quadrant}
  always_comb begin
    dout = '0;
    case ({din[15:13], din[1:0]})
      5'b000_00: if (din[12:5] != '0)
                   dout = {2'b00, din[10:7], din[12:11], din[5], din[6], 2'b00, 5'd2, 3'b000, rdp, OP_IMM};
      5'b010_00: dout = {5'b0, din[5], din[12:10], din[6], 2'b00, rs1p, 3'b010, rdp, OP_LOAD};
      5'b110_00: dout = {5'b0, din[5], din[12], rdp, rs1p, 3'b010, din[11:10], din[6], 2'b00, OP_STORE};
      5'b000_01: dout = {imm6s, rd, 3'b000, rd, OP_IMM};
      5'b001_01: dout = {din[12], din[8], din[10:9], din[6], din[7], din[2], din[11], din[5:3],
                         din[12], {8{din[12]}}, 5'd1, OP_JAL};
      5'b010_01: dout = {imm6s, 5'd0, 3'b000, rd, OP_IMM};
      5'b011_01: begin
        if ({din[12], din[6:2]} != '0) begin
          if (rd == 5'd2)
            dout = {{2{din[12]}}, din[12], din[4:3], din[5], din[2], din[6], 4'b0, 5'd2, 3'b000, 5'd2, OP_IMM};
          else
            dout = {{14{din[12]}}, din[12], din[6:2], rd, OP_LUI};
        end
      end
      5'b100_01: begin
        case (din[11:10])
          2'b00: if (!din[12]) dout = {7'b0000000, din[6:2], rs1p, 3'b101, rs1p, OP_IMM};
          2'b01: if (!din[12]) dout = {7'b0100000, din[6:2], rs1p, 3'b101, rs1p, OP_IMM};
          2'b10: dout = {imm6s, rs1p, 3'b111, rs1p, OP_IMM};
          default: begin
            if (!din[12]) begin
              case (din[6:5])
                2'b00:   dout = {7'b0100000, rdp, rs1p, 3'b000, rs1p, OP_REG};
                2'b01:   dout = {7'b0000000, rdp, rs1p, 3'b100, rs1p, OP_REG};
                2'b10:   dout = {7'b0000000, rdp, rs1p, 3'b110, rs1p, OP_REG};
                default: dout = {7'b0000000, rdp, rs1p, 3'b111, rs1p, OP_REG};
              endcase
            end
          end
        endcase
      end
      5'b101_01: dout = {din[12], din[8], din[10:9], din[6], din[7], din[2], din[11], din[5:3],
                         din[12], {8{din[12]}}, 5'd0, OP_JAL};
      5'b110_01: dout = {{4{din[12]}}, din[6:5], din[2], 5'd0, rs1p, 3'b000,
                         din[11:10], din[4:3], din[12], OP_BRANCH};
      5'b111_01: dout = {{4{din[12]}}, din[6:5], din[2], 5'd0, rs1p, 3'b001,
                         din[11:10], din[4:3], din[12], OP_BRANCH};
      5'b000_10: if (!din[12]) dout = {7'b0000000, din[6:2], rd, 3'b001, rd, OP_IMM};
      5'b010_10: if (rd != '0)
                   dout = {4'b0, din[3:2], din[12], din[6:4], 2'b00, 5'd2, 3'b010, rd, OP_LOAD};
      5'b100_10: begin
        if (!din[12]) begin
          if (rs2 == '0) begin
            if (rd != '0) dout = {12'b0, rd, 3'b000, 5'd0, OP_JALR};
          end else begin
            dout = {7'b0000000, rs2, 5'd0, 3'b000, rd, OP_REG};
          end
        end else begin
          if (rs2 == '0 && rd == '0) dout = 32'h0010_0073;
          else if (rs2 == '0)        dout = {12'b0, rd, 3'b000, 5'd1, OP_JALR};
          else                       dout = {7'b0000000, rs2, rd, 3'b000, rd, OP_REG};
        end
      end
      5'b110_10: dout = {4'b0, din[8:7], din[12], rs2, 5'd2, 3'b010, din[11:9], 2'b00, OP_STORE};
      default:   dout = '0;
    endcase
  end

endmodule

// File: rtl/eh2_ifu_compress_stream.sv
// Fetch-beat parcel FIFO, 16/32-bit instruction aligner and registered RVC expansion.
module eh2_ifu_compress_stream
  import eh2_ifu_pkg::*;
#(
  parameter int NPARCEL   = 2,
  parameter int BUF_DEPTH = 6,
  parameter int PC_W      = 31,
  localparam int SW = (NPARCEL > 1) ? $clog2(NPARCEL) : 1
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [PARCEL_W*NPARCEL-1:0] in_data,
  input  logic [PC_W-1:0]             in_pc,
  input  logic [SW-1:0]               in_start,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [31:0]                 out_instr,
  output logic [PC_W-1:0]             out_pc,
  output logic                        out_compressed,
  output logic                        out_illegal
);

  localparam int PW   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW   = $clog2(BUF_DEPTH + 1);
  localparam int SUMW = PW + CW + 1;

  typedef struct packed {
    parcel_t         data;
    logic [PC_W-1:0] pc;
  } entry_t;

  entry_t        fifo_q [BUF_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] push_n, pop_n;
  entry_t        head;
  parcel_t       second_data;
  logic [31:0]   dout;
  logic          head_full, head_avail, load, in_fire;

  // Pointer advance with wrap at BUF_DEPTH (need not be a power of two)
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [CW-1:0] n);
    logic [SUMW-1:0] s;
    s = SUMW'(p) + SUMW'(n);
    if (s >= SUMW'(BUF_DEPTH)) s = s - SUMW'(BUF_DEPTH);
    return s[PW-1:0];
  endfunction

  assign head        = fifo_q[rd_ptr_q];
  assign second_data = fifo_q[ptr_add(rd_ptr_q, CW'(1))].data;
  assign head_full   = (head.data[1:0] == RVC_FULL_OP);
  assign head_avail  = (count_q != '0) && (!head_full || (count_q >= CW'(2)));
  assign in_ready    = !rst && !flush && ((CW'(BUF_DEPTH) - count_q) >= CW'(NPARCEL));
  assign in_fire     = in_valid && in_ready;
  assign load        = !flush && head_avail && (!out_valid || out_ready);

  eh2_ifu_compress_ctl u_compress_ctl (
    .din  (head.data),
    .dout (dout)
  );

  // Push/pop entry counts for this cycle
  always_comb begin
    push_n = '0;
    if (in_fire && (int'(in_start) < NPARCEL))
      push_n = CW'(NPARCEL - int'(in_start));
    pop_n = '0;
    if (load)
      pop_n = head_full ? CW'(2) : CW'(1);
  end

  // Parcel storage: useful parcels packed contiguously from wr_ptr
  always_ff @(posedge clk) begin
    for (int unsigned j = 0; j < NPARCEL; j++) begin
      if (in_fire && (j >= 32'(in_start)))
        fifo_q[ptr_add(wr_ptr_q, CW'(j - 32'(in_start)))] <=
          '{data: in_data[PARCEL_W*j +: PARCEL_W], pc: in_pc + PC_W'(j)};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= ptr_add(wr_ptr_q, push_n);
      rd_ptr_q <= ptr_add(rd_ptr_q, pop_n);
      count_q  <= count_q + push_n - pop_n;
    end
  end

  // Output register: loads a complete head instruction, holds under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_instr      <= '0;
      out_pc         <= '0;
      out_compressed <= 1'b0;
      out_illegal    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid      <= 1'b1;
      out_instr      <= head_full ? {second_data, head.data} : dout;
      out_pc         <= head.pc;
      out_compressed <= !head_full;
      out_illegal    <= !head_full && (dout == '0);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_eh2_ifu_compress_stream.sv
// Self-checking bench for eh2_ifu_compress_stream: vector table plus corner sequences.
module tb_eh2_ifu_compress_stream;

  localparam int NP = 2;
  localparam int BD = 6;
  localparam int PW = 31;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic          out_compressed, out_illegal;
  logic [31:0]   in_data, out_instr;
  logic [PW-1:0] in_pc, out_pc;
  logic [0:0]    in_start;

  always #5 clk = ~clk;

  eh2_ifu_compress_stream #(.NPARCEL(NP), .BUF_DEPTH(BD), .PC_W(PW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_pc(in_pc), .in_start(in_start),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_compressed(out_compressed), .out_illegal(out_illegal)
  );

  typedef struct {
    logic [31:0]   instr;
    logic [PW-1:0] pc;
    logic          c;
    logic          ill;
  } exp_t;

  typedef struct {
    logic [31:0]   data;
    logic [PW-1:0] pc;
    logic [0:0]    st;
    int            n;
    exp_t          e0;
    exp_t          e1;
  } vec_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mke(input logic [31:0] i, input logic [PW-1:0] p, input logic c, input logic l);
    exp_t e;
    e.instr = i; e.pc = p; e.c = c; e.ill = l;
    return e;
  endfunction

  function automatic vec_t mkv(input logic [31:0] d, input logic [PW-1:0] p, input logic [0:0] st,
                               input int n, input exp_t e0, input exp_t e1);
    vec_t v;
    v.data = d; v.pc = p; v.st = st; v.n = n; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  // Output monitor: scoreboard compare on handshake, stability check while held
  logic          hold_v = 1'b0;
  logic [31:0]   hold_i;
  logic [PW-1:0] hold_pc;
  logic          hold_c, hold_ill;
  always @(negedge clk) begin
    exp_t e;
    if (hold_v) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_instr", out_instr, hold_i);
      chk("hold_pc", out_pc, hold_pc);
      chk("hold_compressed", out_compressed, hold_c);
      chk("hold_illegal", out_illegal, hold_ill);
    end
    hold_v = 1'b0;
    if (!rst && !flush && out_valid) begin
      if (out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output instr=%h pc=%h required=none", out_instr, out_pc);
        end else begin
          e = sb.pop_front();
          chk("out_instr", out_instr, e.instr);
          chk("out_pc", out_pc, e.pc);
          chk("out_compressed", out_compressed, e.c);
          chk("out_illegal", out_illegal, e.ill);
        end
      end else begin
        hold_v = 1'b1; hold_i = out_instr; hold_pc = out_pc;
        hold_c = out_compressed; hold_ill = out_illegal;
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic [PW-1:0] pc, input logic [0:0] st);
    bit ok;
    ok = 1'b0;
    in_data = d; in_pc = pc; in_start = st; in_valid = 1'b1;
    for (int unsigned k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    chk("send_accepted", ok, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int unsigned k = 0; k < 300; k++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    chk(name, sb.size(), 0);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  vec_t tv[9];
  int   acc;
  logic [PW-1:0] bpc;

  initial begin
    tv[0] = mkv(32'h0001_4505, 31'h40, 1'b0, 2, mke(32'h0010_0513, 31'h40, 1, 0), mke(32'h0000_0013, 31'h41, 1, 0));
    tv[1] = mkv(32'h0093_0001, 31'h40, 1'b0, 1, mke(32'h0000_0013, 31'h40, 1, 0), mke(32'h0, 31'h0, 0, 0));
    tv[2] = mkv(32'h0085_0010, 31'h42, 1'b0, 2, mke(32'h0010_0093, 31'h41, 0, 0), mke(32'h0010_8093, 31'h43, 1, 0));
    tv[3] = mkv(32'h4505_0000, 31'h20, 1'b1, 1, mke(32'h0010_0513, 31'h21, 1, 0), mke(32'h0, 31'h0, 0, 0));
    tv[4] = mkv(32'h0001_0000, 31'h30, 1'b0, 2, mke(32'h0000_0000, 31'h30, 1, 1), mke(32'h0000_0013, 31'h31, 1, 0));
    tv[5] = mkv(32'h0010_0513, 31'h50, 1'b0, 1, mke(32'h0010_0513, 31'h50, 0, 0), mke(32'h0, 31'h0, 0, 0));
    tv[6] = mkv(32'h4188_852E, 31'h60, 1'b0, 2, mke(32'h00B0_0533, 31'h60, 1, 0), mke(32'h0005_A503, 31'h61, 1, 0));
    tv[7] = mkv(32'h0001_A001, 31'h70, 1'b0, 2, mke(32'h0000_006F, 31'h70, 1, 0), mke(32'h0000_0013, 31'h71, 1, 0));
    tv[8] = mkv(32'h0001_0001, 31'h7FFF_FFFF, 1'b0, 2, mke(32'h0000_0013, 31'h7FFF_FFFF, 1, 0), mke(32'h0000_0013, 31'h0, 1, 0));

    // Reset with a beat presented
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'h0001_4505;
    in_pc = '0; in_start = 1'b0; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_instr", out_instr, 0);
      chk("rst_out_pc", out_pc, 0);
      chk("rst_out_compressed", out_compressed, 0);
      chk("rst_out_illegal", out_illegal, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);

    // First-instruction latency: accepted in N, visible in N+2, next in N+3
    sb.push_back(mke(32'h0010_0513, 31'h40, 1, 0));
    sb.push_back(mke(32'h0000_0013, 31'h41, 1, 0));
    in_data = 32'h0001_4505; in_pc = 31'h40; in_start = 1'b0; in_valid = 1'b1;
    chk("lat_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); chk("lat_n1_valid", out_valid, 0);
    @(negedge clk); chk("lat_n2_valid", out_valid, 1);
    @(negedge clk); chk("lat_n3_valid", out_valid, 1);
    @(posedge clk); #1;
    wait_drain("lat_drain");

    // Vector table streamed back to back
    for (int unsigned i = 0; i < 9; i++) begin
      sb.push_back(tv[i].e0);
      if (tv[i].n > 1) sb.push_back(tv[i].e1);
      send(tv[i].data, tv[i].pc, tv[i].st);
    end
    wait_drain("table_drain");

    // Backpressure: FIFO plus output register fill to 6 parcels
    out_ready = 1'b0; acc = 0; bpc = 31'h100;
    for (int unsigned c = 0; c < 20; c++) begin
      in_data = 32'h0001_0001; in_pc = bpc; in_start = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(mke(32'h0000_0013, bpc, 1, 0));
        sb.push_back(mke(32'h0000_0013, bpc + 31'd1, 1, 0));
        bpc = bpc + 31'd2;
        acc++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_beats_accepted", acc, 3);
    chk("bp_in_ready", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain("bp_drain");

    // Flush discards a pending upper-half parcel
    sb.push_back(mke(32'h0000_0013, 31'h40, 1, 0));
    send(32'h0093_0001, 31'h40, 1'b0);
    wait_drain("pend_drain");
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h0001_4505; in_pc = 31'h90; in_start = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("post_flush_in_ready", in_ready, 1);
    chk("post_flush_valid", out_valid, 0);
    @(posedge clk); #1;
    sb.push_back(mke(32'h0010_0513, 31'h80, 1, 0));
    sb.push_back(mke(32'h0000_0013, 31'h81, 1, 0));
    send(32'h0001_4505, 31'h80, 1'b0);
    wait_drain("flush_drain");

    // Flush while an output is held under backpressure
    out_ready = 1'b0;
    send(32'h0001_4505, 31'hA0, 1'b0);
    for (int unsigned k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("held_before_flush", out_valid, 1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_clears_valid", out_valid, 0);
    out_ready = 1'b1;
    repeat (6) begin @(posedge clk); #1; end

    // Reset mid-operation clears data registers too
    out_ready = 1'b0;
    send(32'h0001_852E, 31'hB0, 1'b0);
    for (int unsigned k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("held_before_rst", out_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_instr", out_instr, 0);
    chk("midrst_pc", out_pc, 0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    sb.push_back(mke(32'h00B0_0533, 31'hC0, 1, 0));
    sb.push_back(mke(32'h0000_0013, 31'hC1, 1, 0));
    send(32'h0001_852E, 31'hC0, 1'b0);
    wait_drain("final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog_timeout time=%0t required=finish", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
